// File: rtl/spike_link_pkg.sv
// Shared types for the Spike co-simulation commit path: default widths,
// key/value/entry typedefs and the collector state encoding.
package spike_link_pkg;

    localparam int unsigned KEY_WIDTH_DEFAULT   = 64;
    localparam int unsigned VALUE_WIDTH_DEFAULT = 128;

    typedef logic [KEY_WIDTH_DEFAULT-1:0]   key_t;
    typedef logic [VALUE_WIDTH_DEFAULT-1:0] value_t;

    typedef struct packed {
        key_t   key;
        value_t value;
    } entry_t;

    typedef enum logic [1:0] {
        COLLECT   = 2'd0,
        SEAL_WAIT = 2'd1,
        READOUT   = 2'd2
    } state_t;

    // Index width that stays legal for single-entry structures.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/commit_cam.sv
// Key store with parallel match for the commit collector; one write port,
// one combinational match port and one combinational read port.
module commit_cam
    import spike_link_pkg::*;
#(
    parameter  int unsigned KEY_WIDTH = KEY_WIDTH_DEFAULT,
    parameter  int unsigned DEPTH     = 16,
    localparam int unsigned IW        = idx_width(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 wr_en_i,
    input  logic [IW-1:0]        wr_idx_i,
    input  logic [KEY_WIDTH-1:0] wr_key_i,
    input  logic [KEY_WIDTH-1:0] lookup_key_i,
    output logic                 hit_o,
    output logic [IW-1:0]        hit_idx_o,
    input  logic [IW-1:0]        rd_idx_i,
    output logic [KEY_WIDTH-1:0] rd_key_o
);

    logic [KEY_WIDTH-1:0] key_mem [DEPTH];
    logic [DEPTH-1:0]     valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                key_mem[i] <= '0;
            end
        end else if (clear_i) begin
            valid <= '0;
        end else if (wr_en_i) begin
            key_mem[wr_idx_i] <= wr_key_i;
            valid[wr_idx_i]   <= 1'b1;
        end
    end

    // Keys are unique while valid, so at most one entry can match.
    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid[i] && (key_mem[i] == lookup_key_i) && !hit_o) begin
                hit_o     = 1'b1;
                hit_idx_o = IW'(i);
            end
        end
    end

    assign rd_key_o = key_mem[rd_idx_i];

endmodule

// File: rtl/commit_log_collector.sv
// Collects register-file writes per step, deduplicates by key (last write
// wins) and streams the sealed set out one entry per handshake.
module commit_log_collector
    import spike_link_pkg::*;
#(
    parameter  int unsigned NUM_PORTS       = 2,
    parameter  int unsigned KEY_WIDTH       = KEY_WIDTH_DEFAULT,
    parameter  int unsigned VALUE_WIDTH     = VALUE_WIDTH_DEFAULT,
    parameter  int unsigned MAX_ENTRY_COUNT = 16,
    localparam int unsigned CW              = $clog2(MAX_ENTRY_COUNT + 1),
    localparam int unsigned IW              = idx_width(MAX_ENTRY_COUNT),
    localparam int unsigned PW              = idx_width(NUM_PORTS)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_PORTS-1:0]             we_i,
    input  logic [NUM_PORTS*KEY_WIDTH-1:0]   wa_i,
    input  logic [NUM_PORTS*VALUE_WIDTH-1:0] wd_i,
    output logic                             in_ready_o,
    input  logic                             step_done_i,
    input  logic                             clear_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [KEY_WIDTH-1:0]             out_key_o,
    output logic [VALUE_WIDTH-1:0]           out_value_o,
    output logic                             out_last_o,
    output logic [CW-1:0]                    count_o,
    output logic                             overflow_o
);

    state_t                 state;
    logic [NUM_PORTS-1:0]   staged;
    logic [KEY_WIDTH-1:0]   staged_key   [NUM_PORTS];
    logic [VALUE_WIDTH-1:0] staged_value [NUM_PORTS];
    logic [VALUE_WIDTH-1:0] value_mem    [MAX_ENTRY_COUNT];
    logic [IW-1:0]          rd_idx;

    logic                   accept;
    logic                   ins_found;
    logic [PW-1:0]          ins_port;
    logic [KEY_WIDTH-1:0]   ins_key;
    logic [VALUE_WIDTH-1:0] ins_value;
    logic                   hit;
    logic [IW-1:0]          hit_idx;
    logic                   full;
    logic                   ins_append;
    logic                   ins_drop;
    logic [IW-1:0]          ins_idx;
    logic [NUM_PORTS-1:0]   ins_mask;
    logic [NUM_PORTS-1:0]   stage_next;
    logic [CW-1:0]          count_next;
    logic                   enter_readout;
    logic                   readout_end;
    logic [IW-1:0]          rd_sel;
    logic [KEY_WIDTH-1:0]   cam_rd_key;
    logic [KEY_WIDTH-1:0]   first_key;
    logic [VALUE_WIDTH-1:0] first_value;

    assign in_ready_o = (staged == '0) && (state != READOUT);
    assign accept     = in_ready_o && (|we_i);

    always_comb begin
        ins_found = 1'b0;
        ins_port  = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (staged[p] && !ins_found) begin
                ins_found = 1'b1;
                ins_port  = PW'(p);
            end
        end
    end

    assign ins_key    = staged_key[ins_port];
    assign ins_value  = staged_value[ins_port];
    assign full       = (count_o == CW'(MAX_ENTRY_COUNT));
    assign ins_append = ins_found && !hit && !full;
    assign ins_drop   = ins_found && !hit && full;
    assign ins_idx    = hit ? hit_idx : count_o[IW-1:0];
    assign ins_mask   = ins_found ? (NUM_PORTS'(1) << ins_port) : '0;
    assign stage_next = accept ? we_i : (staged & ~ins_mask);
    assign count_next = count_o + CW'(ins_append);

    assign enter_readout = ((state == COLLECT) && step_done_i && (stage_next == '0))
                        || ((state == SEAL_WAIT) && (stage_next == '0));
    assign readout_end   = (state == READOUT)
                        && (!out_valid_o || (out_ready_i && out_last_o));
    assign rd_sel        = (state == READOUT) ? rd_idx + IW'(1) : '0;

    // Entry 0 may be written by the insertion on the sealing edge itself.
    assign first_key   = (ins_append && (count_o == '0)) ? ins_key : cam_rd_key;
    assign first_value = (ins_found && !ins_drop && (ins_idx == '0)) ? ins_value : value_mem[0];

    commit_cam #(
        .KEY_WIDTH (KEY_WIDTH),
        .DEPTH     (MAX_ENTRY_COUNT)
    ) u_cam (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (clear_i || readout_end),
        .wr_en_i      (ins_append && !clear_i),
        .wr_idx_i     (ins_idx),
        .wr_key_i     (ins_key),
        .lookup_key_i (ins_key),
        .hit_o        (hit),
        .hit_idx_o    (hit_idx),
        .rd_idx_i     (rd_sel),
        .rd_key_o     (cam_rd_key)
    );

    always_ff @(posedge clk_i) begin
        if (ins_found && !ins_drop && !clear_i) begin
            value_mem[ins_idx] <= ins_value;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= COLLECT;
            staged      <= '0;
            rd_idx      <= '0;
            count_o     <= '0;
            overflow_o  <= 1'b0;
            out_valid_o <= 1'b0;
            out_key_o   <= '0;
            out_value_o <= '0;
            out_last_o  <= 1'b0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                staged_key[p]   <= '0;
                staged_value[p] <= '0;
            end
        end else if (clear_i) begin
            state       <= COLLECT;
            staged      <= '0;
            rd_idx      <= '0;
            count_o     <= '0;
            overflow_o  <= 1'b0;
            out_valid_o <= 1'b0;
            out_key_o   <= '0;
            out_value_o <= '0;
            out_last_o  <= 1'b0;
        end else begin
            staged <= stage_next;
            if (accept) begin
                for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                    staged_key[p]   <= wa_i[p*KEY_WIDTH +: KEY_WIDTH];
                    staged_value[p] <= wd_i[p*VALUE_WIDTH +: VALUE_WIDTH];
                end
            end
            if (ins_append) count_o <= count_next;
            if (ins_drop) overflow_o <= 1'b1;

            case (state)
                COLLECT, SEAL_WAIT: begin
                    if (enter_readout) begin
                        state       <= READOUT;
                        rd_idx      <= '0;
                        out_valid_o <= (count_next != '0);
                        out_key_o   <= (count_next != '0) ? first_key : '0;
                        out_value_o <= (count_next != '0) ? first_value : '0;
                        out_last_o  <= (count_next == CW'(1));
                    end else if ((state == COLLECT) && step_done_i) begin
                        state <= SEAL_WAIT;
                    end
                end
                READOUT: begin
                    if (readout_end) begin
                        state       <= COLLECT;
                        rd_idx      <= '0;
                        count_o     <= '0;
                        overflow_o  <= 1'b0;
                        out_valid_o <= 1'b0;
                        out_key_o   <= '0;
                        out_value_o <= '0;
                        out_last_o  <= 1'b0;
                    end else if (out_valid_o && out_ready_i) begin
                        rd_idx      <= rd_sel;
                        out_key_o   <= cam_rd_key;
                        out_value_o <= value_mem[rd_sel];
                        out_last_o  <= (CW'(rd_idx) + CW'(2) == count_o);
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_commit_log_collector.sv
// Randomised bench for commit_log_collector against an ordered-map model
// of one step's commits (first-insertion order, last write wins).
module tb_commit_log_collector;

    localparam int NP  = 2;
    localparam int KW  = 64;
    localparam int VW  = 128;
    localparam int MAX = 16;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [NP-1:0]   we_i;
    logic [NP*KW-1:0] wa_i;
    logic [NP*VW-1:0] wd_i;
    logic            in_ready_o;
    logic            step_done_i;
    logic            clear_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [KW-1:0]   out_key_o;
    logic [VW-1:0]   out_value_o;
    logic            out_last_o;
    logic [4:0]      count_o;
    logic            overflow_o;

    int errors = 0;
    int checks = 0;
    int stalls = 0;

    logic [KW-1:0] mkeys[$];
    logic [VW-1:0] mvals[$];
    bit            movf;
    logic [KW-1:0] got_keys[$];
    logic [VW-1:0] got_vals[$];
    bit            got_last[$];

    always #5 clk = ~clk;

    commit_log_collector #(
        .NUM_PORTS       (NP),
        .KEY_WIDTH       (KW),
        .VALUE_WIDTH     (VW),
        .MAX_ENTRY_COUNT (MAX)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .we_i        (we_i),
        .wa_i        (wa_i),
        .wd_i        (wd_i),
        .in_ready_o  (in_ready_o),
        .step_done_i (step_done_i),
        .clear_i     (clear_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_key_o   (out_key_o),
        .out_value_o (out_value_o),
        .out_last_o  (out_last_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        mkeys.delete();
        mvals.delete();
        movf = 1'b0;
    endtask

    task automatic model_apply(input logic [NP-1:0] we, input logic [NP*KW-1:0] ks,
                               input logic [NP*VW-1:0] vs);
        for (int p = 0; p < NP; p++) begin
            if (we[p]) begin
                bit found;
                found = 1'b0;
                foreach (mkeys[i]) begin
                    if (mkeys[i] == ks[p*KW +: KW]) begin
                        mvals[i] = vs[p*VW +: VW];
                        found = 1'b1;
                    end
                end
                if (!found) begin
                    if (mkeys.size() < MAX) begin
                        mkeys.push_back(ks[p*KW +: KW]);
                        mvals.push_back(vs[p*VW +: VW]);
                    end else begin
                        movf = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic drive_write(input logic [NP-1:0] we, input logic [NP*KW-1:0] ks,
                               input logic [NP*VW-1:0] vs, input bit step);
        int n = 0;
        while (!in_ready_o && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready_o) stalls++;
        we_i = we; wa_i = ks; wd_i = vs; step_done_i = step;
        tick();
        model_apply(we, ks, vs);
        we_i = '0; step_done_i = 1'b0;
    endtask

    task automatic rand_write(input int key_max, input bit step);
        logic [NP*KW-1:0] ks;
        logic [NP*VW-1:0] vs;
        ks = {64'($urandom_range(0, key_max)), 64'($urandom_range(0, key_max))};
        vs = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        drive_write(NP'($urandom_range(1, 3)), ks, vs, step);
    endtask

    task automatic drain();
        int n = 0;
        while (!in_ready_o && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready_o) stalls++;
    endtask

    // Captures one step's stream; reports timeout, hold violations and handshake span.
    task automatic receive(input bit toggle, output bit timed_out, output int held_bad,
                           output int span);
        int cyc = 0;
        int first = -1;
        int lastc = -1;
        bit done = 1'b0;
        bit holding = 1'b0;
        logic [KW-1:0] hk;
        logic [VW-1:0] hv;
        got_keys.delete(); got_vals.delete(); got_last.delete();
        held_bad = 0;
        while (!done && cyc < 400) begin
            out_ready_i = toggle ? (cyc % 2 == 1) : 1'b1;
            if (holding && (!out_valid_o || out_key_o !== hk || out_value_o !== hv)) held_bad++;
            holding = 1'b0;
            if (out_valid_o) begin
                if (out_ready_i) begin
                    got_keys.push_back(out_key_o);
                    got_vals.push_back(out_value_o);
                    got_last.push_back(out_last_o);
                    if (first < 0) first = cyc;
                    lastc = cyc;
                    if (out_last_o) done = 1'b1;
                end else begin
                    holding = 1'b1;
                    hk = out_key_o;
                    hv = out_value_o;
                end
            end
            tick();
            cyc++;
        end
        out_ready_i = 1'b0;
        timed_out = !done;
        span = lastc - first;
    endtask

    task automatic test_reset();
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid_o); end
        checks++; if (out_last_o !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %0b expected 0", out_last_o); end
        checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow_o); end
        checks++; if (out_key_o !== '0 || out_value_o !== '0) begin errors++; $display("FAIL reset_out_data: got %0h/%0h expected 0/0", out_key_o, out_value_o); end
    endtask

    task automatic test_two_port();
        bit to; int hb; int sp;
        model_clear();
        drive_write(2'b11, {64'd9, 64'd5}, {128'hB, 128'hA}, 1'b0);
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL two_port_busy1: got %0b expected 0", in_ready_o); end
        tick();
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL two_port_busy2: got %0b expected 0", in_ready_o); end
        tick();
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL two_port_ready: got %0b expected 1", in_ready_o); end
        checks++; if (count_o !== 5'(mkeys.size())) begin errors++; $display("FAIL two_port_count: got %0d expected %0d", count_o, mkeys.size()); end
        drive_write(2'b00, '0, '0, 1'b1);
        receive(1'b0, to, hb, sp);
        checks++; if (to || got_keys.size() != mkeys.size()) begin errors++; $display("FAIL two_port_len: got %0d timeout %0b expected %0d", got_keys.size(), to, mkeys.size()); end
        else foreach (mkeys[i]) begin
            checks++;
            if (got_keys[i] !== mkeys[i] || got_vals[i] !== mvals[i] || got_last[i] !== (i == mkeys.size() - 1))
                begin errors++; $display("FAIL two_port_entry%0d: got %0h/%0h/%0b expected %0h/%0h/%0b", i, got_keys[i], got_vals[i], got_last[i], mkeys[i], mvals[i], i == mkeys.size() - 1); end
        end
        checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL two_port_count_after: got %0d expected 0", count_o); end
    endtask

    task automatic test_collision();
        bit to; int hb; int sp;
        model_clear();
        drive_write(2'b11, {64'd3, 64'd3}, {128'h2, 128'h1}, 1'b0);
        drive_write(2'b01, {64'd0, 64'd3}, {128'h0, 128'h7}, 1'b0);
        drain();
        checks++; if (count_o !== 5'(mkeys.size())) begin errors++; $display("FAIL collision_count: got %0d expected %0d", count_o, mkeys.size()); end
        drive_write(2'b00, '0, '0, 1'b1);
        receive(1'b0, to, hb, sp);
        checks++; if (to || got_keys.size() != mkeys.size()) begin errors++; $display("FAIL collision_len: got %0d timeout %0b expected %0d", got_keys.size(), to, mkeys.size()); end
        else foreach (mkeys[i]) begin
            checks++;
            if (got_keys[i] !== mkeys[i] || got_vals[i] !== mvals[i] || got_last[i] !== (i == mkeys.size() - 1))
                begin errors++; $display("FAIL collision_entry%0d: got %0h/%0h/%0b expected %0h/%0h/%0b", i, got_keys[i], got_vals[i], got_last[i], mkeys[i], mvals[i], i == mkeys.size() - 1); end
        end
    endtask

    task automatic test_overflow();
        bit to; int hb; int sp;
        model_clear();
        for (int i = 0; i < 9; i++) begin
            drive_write((i == 8) ? 2'b01 : 2'b11, {64'(2 * i + 1), 64'(2 * i)},
                        {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0);
        end
        drain();
        checks++; if (overflow_o !== movf) begin errors++; $display("FAIL overflow_flag: got %0b expected %0b", overflow_o, movf); end
        checks++; if (count_o !== 5'(mkeys.size())) begin errors++; $display("FAIL overflow_count: got %0d expected %0d", count_o, mkeys.size()); end
        drive_write(2'b00, '0, '0, 1'b1);
        receive(1'b0, to, hb, sp);
        checks++; if (to || got_keys.size() != mkeys.size()) begin errors++; $display("FAIL overflow_len: got %0d timeout %0b expected %0d", got_keys.size(), to, mkeys.size()); end
        else foreach (mkeys[i]) begin
            checks++;
            if (got_keys[i] !== mkeys[i] || got_vals[i] !== mvals[i] || got_last[i] !== (i == mkeys.size() - 1))
                begin errors++; $display("FAIL overflow_entry%0d: got %0h/%0h/%0b expected %0h/%0h/%0b", i, got_keys[i], got_vals[i], got_last[i], mkeys[i], mvals[i], i == mkeys.size() - 1); end
        end
        checks++; if (overflow_o !== 1'b0 || count_o !== 5'd0) begin errors++; $display("FAIL overflow_cleared: got %0b/%0d expected 0/0", overflow_o, count_o); end
    endtask

    task automatic test_seal_wait();
        bit to; int hb; int sp;
        model_clear();
        rand_write(3, 1'b0);
        drain();
        drive_write(2'b11, {64'($urandom_range(0, 5)), 64'($urandom_range(0, 5))},
                    {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (out_valid_o !== 1'b0 || in_ready_o !== 1'b0) begin errors++; $display("FAIL seal_wait_cycle%0d: got valid %0b ready %0b expected 0/0", c, out_valid_o, in_ready_o); end
            tick();
        end
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL seal_wait_valid: got %0b expected 1", out_valid_o); end
        receive(1'b0, to, hb, sp);
        checks++; if (to || got_keys.size() != mkeys.size()) begin errors++; $display("FAIL seal_wait_len: got %0d timeout %0b expected %0d", got_keys.size(), to, mkeys.size()); end
        else foreach (mkeys[i]) begin
            checks++;
            if (got_keys[i] !== mkeys[i] || got_vals[i] !== mvals[i] || got_last[i] !== (i == mkeys.size() - 1))
                begin errors++; $display("FAIL seal_wait_entry%0d: got %0h/%0h/%0b expected %0h/%0h/%0b", i, got_keys[i], got_vals[i], got_last[i], mkeys[i], mvals[i], i == mkeys.size() - 1); end
        end
    endtask

    task automatic test_toggle_ready();
        bit to; int hb; int sp;
        model_clear();
        for (int i = 0; i < 8; i++) rand_write(7, i == 7);
        receive(1'b1, to, hb, sp);
        checks++; if (hb != 0) begin errors++; $display("FAIL toggle_hold: got %0d violations expected 0", hb); end
        checks++; if (to || got_keys.size() != mkeys.size()) begin errors++; $display("FAIL toggle_len: got %0d timeout %0b expected %0d", got_keys.size(), to, mkeys.size()); end
        else foreach (mkeys[i]) begin
            checks++;
            if (got_keys[i] !== mkeys[i] || got_vals[i] !== mvals[i] || got_last[i] !== (i == mkeys.size() - 1))
                begin errors++; $display("FAIL toggle_entry%0d: got %0h/%0h/%0b expected %0h/%0h/%0b", i, got_keys[i], got_vals[i], got_last[i], mkeys[i], mvals[i], i == mkeys.size() - 1); end
        end
    endtask

    task automatic test_empty_step();
        model_clear();
        drive_write(2'b00, '0, '0, 1'b1);
        checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b0) begin errors++; $display("FAIL empty_readout: got valid %0b ready %0b expected 0/0", out_valid_o, in_ready_o); end
        tick();
        checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin errors++; $display("FAIL empty_back: got valid %0b ready %0b expected 0/1", out_valid_o, in_ready_o); end
    endtask

    task automatic test_back_to_back();
        bit to; int hb; int sp;
        model_clear();
        for (int i = 0; i < 6; i++) rand_write(1000, 1'b0);
        drive_write(2'b00, '0, '0, 1'b1);
        receive(1'b0, to, hb, sp);
        checks++; if (to || sp != mkeys.size() - 1) begin errors++; $display("FAIL b2b_span: got %0d timeout %0b expected %0d", sp, to, mkeys.size() - 1); end
        checks++; if (got_keys.size() != mkeys.size()) begin errors++; $display("FAIL b2b_len: got %0d expected %0d", got_keys.size(), mkeys.size()); end
        else foreach (mkeys[i]) begin
            checks++;
            if (got_keys[i] !== mkeys[i] || got_vals[i] !== mvals[i] || got_last[i] !== (i == mkeys.size() - 1))
                begin errors++; $display("FAIL b2b_entry%0d: got %0h/%0h/%0b expected %0h/%0h/%0b", i, got_keys[i], got_vals[i], got_last[i], mkeys[i], mvals[i], i == mkeys.size() - 1); end
        end
    endtask

    task automatic test_reset_mid_readout();
        bit to; int hb; int sp; int n = 0;
        model_clear();
        for (int i = 0; i < 3; i++) rand_write(50, i == 2);
        while (!out_valid_o && n < 50) begin tick(); n++; end
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL rst_mid_valid: got %0b expected 1", out_valid_o); end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        rst_i = 1'b1;
        #1;
        checks++; if (out_valid_o !== 1'b0 || out_last_o !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got valid %0b last %0b expected 0/0", out_valid_o, out_last_o); end
        checks++; if (out_key_o !== '0 || out_value_o !== '0) begin errors++; $display("FAIL rst_mid_data: got %0h/%0h expected 0/0", out_key_o, out_value_o); end
        checks++; if (count_o !== 5'd0 || overflow_o !== 1'b0) begin errors++; $display("FAIL rst_mid_count: got %0d/%0b expected 0/0", count_o, overflow_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %0b expected 1", in_ready_o); end
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) rand_write(50, i == 2);
        receive(1'b0, to, hb, sp);
        checks++; if (to || got_keys.size() != mkeys.size()) begin errors++; $display("FAIL rst_mid_len: got %0d timeout %0b expected %0d", got_keys.size(), to, mkeys.size()); end
        else foreach (mkeys[i]) begin
            checks++;
            if (got_keys[i] !== mkeys[i] || got_vals[i] !== mvals[i] || got_last[i] !== (i == mkeys.size() - 1))
                begin errors++; $display("FAIL rst_mid_entry%0d: got %0h/%0h/%0b expected %0h/%0h/%0b", i, got_keys[i], got_vals[i], got_last[i], mkeys[i], mvals[i], i == mkeys.size() - 1); end
        end
    endtask

    task automatic test_clear();
        bit to; int hb; int sp;
        model_clear();
        for (int i = 0; i < 3; i++) rand_write(50, 1'b0);
        drain();
        clear_i = 1'b1; step_done_i = 1'b1; we_i = 2'b11;
        wa_i = {64'd77, 64'd78}; wd_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        tick();
        clear_i = 1'b0; step_done_i = 1'b0; we_i = '0;
        model_clear();
        checks++; if (count_o !== 5'd0 || in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin errors++; $display("FAIL clear_state: got count %0d ready %0b valid %0b expected 0/1/0", count_o, in_ready_o, out_valid_o); end
        rand_write(50, 1'b1);
        receive(1'b0, to, hb, sp);
        checks++; if (to || got_keys.size() != mkeys.size()) begin errors++; $display("FAIL clear_len: got %0d timeout %0b expected %0d", got_keys.size(), to, mkeys.size()); end
        else foreach (mkeys[i]) begin
            checks++;
            if (got_keys[i] !== mkeys[i] || got_vals[i] !== mvals[i] || got_last[i] !== (i == mkeys.size() - 1))
                begin errors++; $display("FAIL clear_entry%0d: got %0h/%0h/%0b expected %0h/%0h/%0b", i, got_keys[i], got_vals[i], got_last[i], mkeys[i], mvals[i], i == mkeys.size() - 1); end
        end
    endtask

    task automatic test_no_stalls();
        checks++; if (stalls != 0) begin errors++; $display("FAIL input_wait_timeout: got %0d expired waits expected 0", stalls); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; we_i = '0; wa_i = '0; wd_i = '0;
        step_done_i = 1'b0; clear_i = 1'b0; out_ready_i = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        test_reset();
        test_two_port();
        test_collision();
        test_overflow();
        test_seal_wait();
        test_toggle_ready();
        test_empty_step();
        test_back_to_back();
        test_reset_mid_readout();
        test_clear();
        test_no_stalls();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
